// File: rtl/mips_lsu_pkg.sv
// Shared encodings for the MIPS load/store unit: access sizes, FSM states, byte-enable constants.
package mips_lsu_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [3:0] BE_ALL  = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_RESP = 2'd2
    } lsu_state_t;

    // Reserved size is treated like a word for alignment purposes.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return (size == SZ_HALF && off[0]) || (size[1] && off != 2'b00);
    endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte enables and replicated store data,
// plus load extraction and sign/zero extension from the memory read word.
module lsu_lane_align
    import mips_lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        sgn,
    input  logic [31:0] wdata,
    input  logic [31:0] dout,
    output logic [3:0]  be,
    output logic [31:0] din,
    output logic [31:0] rdata
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b     = dout[{addr_lo, 3'b000} +: 8];
        h     = addr_lo[1] ? dout[31:16] : dout[15:0];
        be    = BE_ALL;
        din   = wdata;
        rdata = dout;
        case (size)
            SZ_BYTE: begin
                be    = 4'b0001 << addr_lo;
                din   = {4{wdata[7:0]}};
                rdata = {{24{sgn & b[7]}}, b};
            end
            SZ_HALF: begin
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                din   = {2{wdata[15:0]}};
                rdata = {{16{sgn & h[15]}}, h};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mips_lsu.sv
// Load/store initiator for word-addressed data memory: IDLE -> ACC -> RESP per access.
// Define ALIGN_CHECK_EN to suppress and flag misaligned half/word accesses via resp_err.
module mips_lsu
    import mips_lsu_pkg::*;
#(
    parameter int AW = 13,
    parameter int DW = 32
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_signed,
    input  logic [DW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [DW-1:0] resp_rdata,
    output logic          resp_err,
    output logic [AW-1:0] A,
    output logic [DW-1:0] Din,
    output logic [3:0]    BE,
    output logic          We,
    input  logic [DW-1:0] Dout
);
    lsu_state_t    state;
    logic          we_q, sgn_q, mis_q;
    logic [1:0]    size_q;
    logic [AW+1:0] addr_q;
    logic          mis_req;
    logic [1:0]    al_size, al_lo;
    logic [3:0]    al_be;
    logic [DW-1:0] al_din, al_rdata;
    logic          unused_addr;

    assign unused_addr = ^req_addr[DW-1:AW+2];
    assign A = addr_q[AW+1:2];

`ifdef ALIGN_CHECK_EN
    assign mis_req = misaligned(req_size, req_addr[1:0]);
`else
    assign mis_req = 1'b0;
`endif

    // One aligner serves both phases: request fields in IDLE (to register BE/Din),
    // latched fields in ACC (to extract the load result).
    assign al_size = (state == S_IDLE) ? req_size      : size_q;
    assign al_lo   = (state == S_IDLE) ? req_addr[1:0] : addr_q[1:0];

    lsu_lane_align u_align (
        .size    (al_size),
        .addr_lo (al_lo),
        .sgn     (sgn_q),
        .wdata   (req_wdata),
        .dout    (Dout),
        .be      (al_be),
        .din     (al_din),
        .rdata   (al_rdata)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            addr_q     <= '0;
            Din        <= '0;
            BE         <= '0;
            We         <= 1'b0;
            we_q       <= 1'b0;
            sgn_q      <= 1'b0;
            mis_q      <= 1'b0;
            size_q     <= SZ_BYTE;
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    state     <= S_ACC;
                    req_ready <= 1'b0;
                    we_q      <= req_we;
                    sgn_q     <= req_signed;
                    size_q    <= req_size;
                    mis_q     <= mis_req;
                    addr_q    <= req_addr[AW+1:0];
                    Din       <= al_din;
                    BE        <= mis_req ? 4'b0000 : al_be;
                    We        <= req_we & ~mis_req;
                end
                S_ACC: begin
                    state      <= S_RESP;
                    We         <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_rdata <= (we_q || mis_q) ? '0 : al_rdata;
                    resp_err   <= mis_q;
                end
                S_RESP: if (resp_ready) begin
                    state      <= S_IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
